// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: four result lanes in,
// one register-file write port and hazard mask out.
interface wb_arbiter_if #(
  parameter int NREGS = 16
);
  logic [3:0]       lane_valid;
  logic [3:0]       lane_ready;
  logic [3:0]       alu_rd;
  logic [3:0]       ld_rd;
  logic [3:0]       mul_rd;
  logic [3:0]       div_rd;
  logic [31:0]      alu_data;
  logic [31:0]      ld_data;
  logic [31:0]      mul_data;
  logic [31:0]      div_data;
  logic             rf_we;
  logic [3:0]       rf_waddr;
  logic [31:0]      rf_wdata;
  logic [NREGS-1:0] busy_mask;
  logic [3:0]       lane_grant;

  modport master (
    output lane_valid,
    output alu_rd, ld_rd, mul_rd, div_rd,
    output alu_data, ld_data, mul_data, div_data,
    input  lane_ready,
    input  rf_we, rf_waddr, rf_wdata,
    input  busy_mask, lane_grant
  );

  modport slave (
    input  lane_valid,
    input  alu_rd, ld_rd, mul_rd, div_rd,
    input  alu_data, ld_data, mul_data, div_data,
    output lane_ready,
    output rf_we, rf_waddr, rf_wdata,
    output busy_mask, lane_grant
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-lane FIFOs drained round-robin
// into the single register-file write port.
module wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int NREGS = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_arbiter_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]    in_rd   [4];
  logic [31:0]   in_data [4];

  logic [3:0]    rd_q   [4][DEPTH];
  logic [31:0]   data_q [4][DEPTH];
  logic [AW-1:0] wptr [4];
  logic [AW-1:0] rptr [4];
  logic [CW-1:0] cnt  [4];

  logic [1:0]       rr_ptr;
  logic [3:0]       ready;
  logic [3:0]       push;
  logic [3:0]       pop;
  logic [3:0]       cand;
  logic             found;
  logic [1:0]       win;
  logic [AW-1:0]    off;
  logic [NREGS-1:0] mask;

  assign in_rd[3]   = bus.alu_rd;
  assign in_rd[2]   = bus.ld_rd;
  assign in_rd[1]   = bus.mul_rd;
  assign in_rd[0]   = bus.div_rd;
  assign in_data[3] = bus.alu_data;
  assign in_data[2] = bus.ld_data;
  assign in_data[1] = bus.mul_data;
  assign in_data[0] = bus.div_data;

  // ready looks only at registered count, never at this cycle's pop
  always_comb begin
    cand  = '0;
    ready = '0;
    for (int i = 0; i < 4; i++) begin
      cand[i]  = (cnt[i] != '0);
      ready[i] = (cnt[i] != CW'(DEPTH));
    end
  end

  assign push = bus.lane_valid & ready;

  always_comb begin
    found = 1'b0;
    win   = rr_ptr;
    for (int j = 0; j < 4; j++) begin
      if (!found && cand[rr_ptr - 2'(j)]) begin
        found = 1'b1;
        win   = rr_ptr - 2'(j);
      end
    end
  end

  assign pop = found ? (4'b0001 << win) : 4'b0000;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) begin
        rd_q[i][wptr[i]]   <= in_rd[i];
        data_q[i][wptr[i]] <= in_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i])
          wptr[i] <= wptr[i] + AW'(1);
        if (pop[i])
          rptr[i] <= rptr[i] + AW'(1);
        if (push[i] && !pop[i])
          cnt[i] <= cnt[i] + CW'(1);
        else if (!push[i] && pop[i])
          cnt[i] <= cnt[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rf_we      <= 1'b0;
      bus.rf_waddr   <= '0;
      bus.rf_wdata   <= '0;
      bus.lane_grant <= '0;
      rr_ptr         <= 2'd3;
    end else if (found) begin
      bus.rf_we      <= 1'b1;
      bus.rf_waddr   <= rd_q[win][rptr[win]];
      bus.rf_wdata   <= data_q[win][rptr[win]];
      bus.lane_grant <= pop;
      rr_ptr         <= win - 2'd1;
    end else begin
      bus.rf_we      <= 1'b0;
      bus.lane_grant <= '0;
    end
  end

  // live entries sit at offsets 0..cnt-1 from the read pointer
  always_comb begin
    mask = '0;
    off  = '0;
    for (int i = 0; i < 4; i++) begin
      for (int e = 0; e < DEPTH; e++) begin
        off = AW'(e) - rptr[i];
        if ({1'b0, off} < cnt[i])
          mask[rd_q[i][e]] = 1'b1;
      end
    end
    if (bus.rf_we)
      mask[bus.rf_waddr] = 1'b1;
  end

  assign bus.busy_mask  = mask;
  assign bus.lane_ready = ready;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: push, round-robin,
// backpressure, fairness, reset and hazard mask.
module tb_wb_arbiter;
  logic clk;
  logic rst_n;
  int   nvec;
  int   nerr;

  wb_arbiter_if #(.NREGS(16)) bus ();

  wb_arbiter #(
    .DEPTH(2),
    .NREGS(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t exceeded", $time);
    $fatal(1);
  end

  task automatic idle();
    bus.lane_valid = 4'b0000;
    bus.alu_rd = 4'd0;
    bus.ld_rd  = 4'd0;
    bus.mul_rd = 4'd0;
    bus.div_rd = 4'd0;
    bus.alu_data = 32'd0;
    bus.ld_data  = 32'd0;
    bus.mul_data = 32'd0;
    bus.div_data = 32'd0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    nvec++;
    if (bus.rf_we !== 1'b0) begin
      nerr++;
      $display("FAIL reset_we: got %b want 0", bus.rf_we);
    end
    nvec++;
    if (bus.rf_waddr !== 4'd0 || bus.rf_wdata !== 32'd0) begin
      nerr++;
      $display("FAIL reset_addr_data: got %h/%h want 0/0",
               bus.rf_waddr, bus.rf_wdata);
    end
    nvec++;
    if (bus.lane_grant !== 4'b0000) begin
      nerr++;
      $display("FAIL reset_grant: got %b want 0000", bus.lane_grant);
    end
    nvec++;
    if (bus.busy_mask !== 16'h0000) begin
      nerr++;
      $display("FAIL reset_busy: got %h want 0000", bus.busy_mask);
    end
    nvec++;
    if (bus.lane_ready !== 4'b1111) begin
      nerr++;
      $display("FAIL reset_ready: got %b want 1111", bus.lane_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bus.lane_valid = 4'b1000;
    bus.alu_rd = 4'd5;
    bus.alu_data = 32'hDEADBEEF;
    @(negedge clk);
    idle();
    nvec++;
    if (bus.busy_mask !== 16'h0020 || bus.rf_we !== 1'b0) begin
      nerr++;
      $display("FAIL single_queued: busy %h we %b want 0020 0",
               bus.busy_mask, bus.rf_we);
    end
    @(negedge clk);
    nvec++;
    if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 4'd5 ||
        bus.rf_wdata !== 32'hDEADBEEF) begin
      nerr++;
      $display("FAIL single_write: got %b %h %h want 1 5 deadbeef",
               bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    nvec++;
    if (bus.lane_grant !== 4'b1000 || bus.busy_mask !== 16'h0020) begin
      nerr++;
      $display("FAIL single_grant: grant %b busy %h want 1000 0020",
               bus.lane_grant, bus.busy_mask);
    end
    @(negedge clk);
    nvec++;
    if (bus.rf_we !== 1'b0 || bus.busy_mask !== 16'h0000) begin
      nerr++;
      $display("FAIL single_done: we %b busy %h want 0 0000",
               bus.rf_we, bus.busy_mask);
    end
    nvec++;
    if (bus.rf_waddr !== 4'd5 || bus.lane_grant !== 4'b0000) begin
      nerr++;
      $display("FAIL single_hold: addr %h grant %b want 5 0000",
               bus.rf_waddr, bus.lane_grant);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] g;
    do_reset();
    bus.lane_valid = 4'b1111;
    bus.alu_rd = 4'd1;
    bus.ld_rd  = 4'd2;
    bus.mul_rd = 4'd3;
    bus.div_rd = 4'd4;
    bus.alu_data = 32'h101;
    bus.ld_data  = 32'h102;
    bus.mul_data = 32'h103;
    bus.div_data = 32'h104;
    @(negedge clk);
    idle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      g = 4'b1000 >> k;
      nvec++;
      if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 4'(k + 1) ||
          bus.rf_wdata !== 32'(32'h101 + k) || bus.lane_grant !== g) begin
        nerr++;
        $display("FAIL rr_%0d: got %b %h %h %b want 1 %h %h %b",
                 k, bus.rf_we, bus.rf_waddr, bus.rf_wdata,
                 bus.lane_grant, k + 1, 32'h101 + k, g);
      end
    end
    // pointer back at 3: ALU must win over LD
    bus.lane_valid = 4'b1100;
    bus.alu_rd = 4'd8;
    bus.ld_rd  = 4'd9;
    @(negedge clk);
    idle();
    @(negedge clk);
    nvec++;
    if (bus.lane_grant !== 4'b1000 || bus.rf_waddr !== 4'd8) begin
      nerr++;
      $display("FAIL rr_wrap_first: got %b %h want 1000 8",
               bus.lane_grant, bus.rf_waddr);
    end
    @(negedge clk);
    nvec++;
    if (bus.lane_grant !== 4'b0100 || bus.rf_waddr !== 4'd9) begin
      nerr++;
      $display("FAIL rr_wrap_second: got %b %h want 0100 9",
               bus.lane_grant, bus.rf_waddr);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int  m_idx;
    int  a_idx;
    int  m_out;
    int  a_out;
    bit  m_acc;
    bit  a_acc;
    do_reset();
    m_idx = 0;
    a_idx = 0;
    m_out = 0;
    a_out = 0;
    m_acc = 0;
    a_acc = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.rf_we === 1'b1 && bus.lane_grant === 4'b0010) begin
        nvec++;
        if (bus.rf_wdata !== 32'(32'hB000_0000 + m_out) ||
            bus.rf_waddr !== 4'd11) begin
          nerr++;
          $display("FAIL bp_mul_order: got %h/%h want %h/b",
                   bus.rf_wdata, bus.rf_waddr, 32'hB000_0000 + m_out);
        end
        m_out++;
      end
      if (bus.rf_we === 1'b1 && bus.lane_grant === 4'b1000) begin
        nvec++;
        if (bus.rf_wdata !== 32'(32'hA000_0000 + a_out)) begin
          nerr++;
          $display("FAIL bp_alu_order: got %h want %h",
                   bus.rf_wdata, 32'hA000_0000 + a_out);
        end
        a_out++;
      end
      if (m_acc) begin
        m_idx++;
        if (m_idx == 2) begin
          nvec++;
          if (bus.lane_ready[1] !== 1'b0) begin
            nerr++;
            $display("FAIL bp_mul_full: ready %b want 0",
                     bus.lane_ready[1]);
          end
        end
      end
      if (a_acc)
        a_idx++;
      bus.lane_valid[1] = (m_idx < 3);
      bus.mul_rd   = 4'd11;
      bus.mul_data = 32'(32'hB000_0000 + m_idx);
      bus.lane_valid[3] = (a_idx < 6);
      bus.alu_rd   = 4'd10;
      bus.alu_data = 32'(32'hA000_0000 + a_idx);
      m_acc = bus.lane_valid[1] && bus.lane_ready[1];
      a_acc = bus.lane_valid[3] && bus.lane_ready[3];
      @(negedge clk);
    end
    idle();
    nvec++;
    if (m_out != 3 || m_idx != 3) begin
      nerr++;
      $display("FAIL bp_mul_count: out %0d in %0d want 3 3", m_out, m_idx);
    end
    nvec++;
    if (a_out != 6) begin
      nerr++;
      $display("FAIL bp_alu_count: got %0d want 6", a_out);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] g;
    do_reset();
    bus.lane_valid = 4'b1001;
    bus.alu_rd = 4'd12;
    bus.div_rd = 4'd13;
    for (int c = 0; c < 14; c++) begin
      bus.alu_data = 32'(c);
      bus.div_data = 32'(c + 100);
      @(negedge clk);
      if (c >= 1) begin
        g = (c % 2 == 1) ? 4'b1000 : 4'b0001;
        nvec++;
        if (bus.rf_we !== 1'b1 || bus.lane_grant !== g) begin
          nerr++;
          $display("FAIL fair_%0d: got %b %b want 1 %b",
                   c, bus.rf_we, bus.lane_grant, g);
        end
      end
    end
    idle();
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.lane_valid = 4'b1100;
    bus.alu_rd = 4'd2;
    bus.ld_rd  = 4'd6;
    bus.alu_data = 32'h200;
    bus.ld_data  = 32'h600;
    @(negedge clk);
    bus.alu_data = 32'h201;
    bus.ld_data  = 32'h601;
    @(negedge clk);
    idle();
    nvec++;
    if (bus.busy_mask[6] !== 1'b1 || bus.rf_we !== 1'b1) begin
      nerr++;
      $display("FAIL mid_before: busy %h we %b want bit6 1",
               bus.busy_mask, bus.rf_we);
    end
    #2;
    rst_n = 1'b0;
    #1;
    nvec++;
    if (bus.lane_ready !== 4'b1111 || bus.busy_mask !== 16'h0000 ||
        bus.rf_we !== 1'b0 || bus.lane_grant !== 4'b0000) begin
      nerr++;
      $display("FAIL mid_async: ready %b busy %h we %b grant %b",
               bus.lane_ready, bus.busy_mask, bus.rf_we, bus.lane_grant);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      nvec++;
      if (bus.rf_we !== 1'b0) begin
        nerr++;
        $display("FAIL mid_after_%0d: we %b want 0", c, bus.rf_we);
      end
    end
  endtask

  task automatic test_busy_overlap();
    do_reset();
    bus.lane_valid = 4'b0101;
    bus.ld_rd  = 4'd7;
    bus.div_rd = 4'd7;
    bus.ld_data  = 32'h7004;
    bus.div_data = 32'h7001;
    @(negedge clk);
    idle();
    nvec++;
    if (bus.busy_mask !== 16'h0080 || bus.rf_we !== 1'b0) begin
      nerr++;
      $display("FAIL ovl_queued: busy %h we %b want 0080 0",
               bus.busy_mask, bus.rf_we);
    end
    @(negedge clk);
    nvec++;
    if (bus.lane_grant !== 4'b0100 || bus.rf_wdata !== 32'h7004 ||
        bus.busy_mask !== 16'h0080) begin
      nerr++;
      $display("FAIL ovl_first: %b %h %h want 0100 7004 0080",
               bus.lane_grant, bus.rf_wdata, bus.busy_mask);
    end
    @(negedge clk);
    nvec++;
    if (bus.lane_grant !== 4'b0001 || bus.rf_wdata !== 32'h7001 ||
        bus.busy_mask !== 16'h0080) begin
      nerr++;
      $display("FAIL ovl_second: %b %h %h want 0001 7001 0080",
               bus.lane_grant, bus.rf_wdata, bus.busy_mask);
    end
    @(negedge clk);
    nvec++;
    if (bus.rf_we !== 1'b0 || bus.busy_mask !== 16'h0000) begin
      nerr++;
      $display("FAIL ovl_clear: we %b busy %h want 0 0000",
               bus.rf_we, bus.busy_mask);
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_fairness();
    test_reset_mid();
    test_busy_overlap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-side consumer of the four EXE/WB result lanes: ALU (lane 3), LD (lane 2), MUL (lane 1) and DIV (lane 0).
- Each lane delivers a destination register and a 32-bit result under a valid/ready handshake into a small per-lane FIFO.
- A round-robin arbiter drains the FIFOs into the single register-file write port, one write per cycle.
- A pending-destination mask is exported to the hazard/forwarding logic.

Parameters:
- DEPTH, 2, entries per lane FIFO; power of two, minimum 2.
- NREGS, 16, register-file size; equals 2^4, matching the 4-bit register index.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lane_valid  in  4  per-lane result valid; bit 3 ALU, bit 2 LD, bit 1 MUL, bit 0 DIV.
- lane_ready  out  4  per-lane FIFO not full.
- alu_rd, ld_rd, mul_rd, div_rd  in  4 each  destination register per lane.
- alu_data, ld_data, mul_data, div_data  in  32 each  result per lane.
- rf_we  out  1  register-file write enable, registered.
- rf_waddr  out  4  write address, registered.
- rf_wdata  out  32  write data, registered.
- busy_mask  out  NREGS  bit r set while any queued or outgoing write targets register r.
- lane_grant  out  4  one-hot; the lane whose entry is driven on rf_* this cycle, registered alongside rf_we.

Behaviour:
- Reset (asynchronous, rst_n low):
  - All FIFOs empty; occupancy counters 0.
  - rf_we=0, rf_waddr=0, rf_wdata=0, lane_grant=0.
  - rr_ptr=3.
  - Outputs after reset: busy_mask=0, lane_ready=4'b1111.
  - Reset mid-operation discards all queued entries; no rf_we pulse follows deassertion.
- Push:
  - An entry is accepted on a rising edge when lane_valid[i] && lane_ready[i].
  - lane_ready[i] = (count[i] != DEPTH). It depends only on registered state, never on this cycle's pop, so a full FIFO refuses a push even while being popped.
  - valid asserted while ready=0 is ignored. The producer holds its data.
- FIFO:
  - Circular buffer with wrapping read/write pointers and a 0..DEPTH counter.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves count unchanged.
- Arbitration (combinational, every cycle):
  - Candidates are the lanes with count != 0.
  - Search starts at lane rr_ptr and descends with wrap: rr_ptr, rr_ptr-1, …, 0, 3, ….
  - The first candidate found wins, and its head entry is popped at the next edge.
  - On a grant to lane k, rr_ptr <= (k==0) ? 3 : k-1.
  - With no candidate, rr_ptr holds.
- Output register:
  - On each edge, rf_we <= any candidate, with rf_waddr/rf_wdata taken from the winner's head and lane_grant set to the winner's one-hot.
  - With no candidate, rf_we <= 0 and rf_waddr/rf_wdata hold their last values.
  - Minimum latency: data accepted at edge N appears with rf_we=1 after edge N+1.
  - Sustained throughput: 1 write/cycle total.
- Writes to register 0 are passed through unfiltered. Register-file policy decides.
- busy_mask (combinational):
  - OR over every valid FIFO entry of onehot(rd).
  - Also includes onehot(rf_waddr) while rf_we=1.
- Ordering:
  - Entries within a lane leave in push order.
  - There is no cross-lane ordering guarantee. The issue logic must not issue a second writer to a register whose busy_mask bit is set.

Test Plan:
- Reset then single push: ALU valid with rd=5, data=0xDEADBEEF at edge 1. busy_mask[5]=1 immediately after. After edge 2: rf_we=1, waddr=5, wdata=0xDEADBEEF, lane_grant=4'b1000. After edge 3: rf_we=0, busy_mask=0.
- Round-robin: all four lanes push one entry in the same cycle (rd=1,2,3,4 for ALU,LD,MUL,DIV). Writes appear on consecutive cycles with waddr 1,2,3,4 and lane_grant 1000,0100,0010,0001. Final rr_ptr=3.
- Full/backpressure: DEPTH=2, MUL lane pushes 3 entries back-to-back while ALU is continuously fed. Required:
  - lane_ready[1] drops after the 2nd MUL accept.
  - The 3rd MUL entry is held until space frees.
  - No MUL entry is lost or duplicated.
  - MUL data emerges in push order.
- Fairness: ALU and DIV pushed continuously. Grants alternate ALU/DIV with no lane starved for more than 3 cycles.
- Reset mid-operation: 2 entries queued in LD, then rst_n pulsed low between edges. Immediately: lane_ready=1111, busy_mask=0, rf_we=0. No write occurs after reset release.
- busy_mask overlap: LD rd=7 and DIV rd=7 both queued. busy_mask[7] stays 1 until the second write has left rf_*, then clears.
